// File: rtl/lcd_game_engine.sv
// lcd_game_engine
//   Game-logic stage that feeds the 32-character LCD frame writer. It debounces
//   the raw up/down buttons and runs the dodge game (title / play / dead). It
//   presents the game state, the cursor position and the stone position as linear
//   character indices 0..31, where bit 4 selects the row. Game state only advances
//   on frame_done, so every LCD frame shows one consistent snapshot.
//
//   Optional feature macro: SPEEDUP_EN. When it is defined, every stone wrap
//   shortens the step period by one frame, down to MIN_FRAMES.
//
// Ports
//   clk         in   1  system clock
//   reset       in   1  synchronous, active-high reset
//   upB         in   1  raw up button (asynchronous, active-high)
//   dwB         in   1  raw down button (asynchronous, active-high)
//   frame_done  in   1  one-cycle pulse from the LCD writer after char 31
//   game_state  out  2  0=TITLE, 1=PLAY, 3=DEAD
//   cursor      out  5  player char index (column 0 of either row: 0 or 16)
//   stone0      out  5  stone char index
//   score       out  8  stones dodged, saturating at 255

module lcd_game_engine #(
    parameter int DEB_W       = 16,
    parameter int DEB_CYCLES  = 20000,
    parameter int TICK_FRAMES = 8,
    parameter int MIN_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upB,
    input  logic       dwB,
    input  logic       frame_done,
    output logic [1:0] game_state,
    output logic [4:0] cursor,
    output logic [4:0] stone0,
    output logic [7:0] score
);

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        PLAY  = 2'd1,
        DEAD  = 2'd3
    } state_t;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [7:0]       TICK_P   = 8'(TICK_FRAMES);

    // The period can only shrink towards MIN_FRAMES, so a floor above the
    // starting period (or a zero floor) would describe an impossible game.
    if (MIN_FRAMES < 1 || MIN_FRAMES > TICK_FRAMES) begin : g_param_check
        $error("lcd_game_engine: MIN_FRAMES must lie in 1..TICK_FRAMES");
    end

    // Bit 0 is the up button and bit 1 is the down button throughout.
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       level;
    logic [1:0]       rise;
    logic [1:0]       flag;
    logic [1:0]       press;
    logic [DEB_W-1:0] deb_cnt [2];

    assign raw = {dwB, upB};

    // A rising debounced edge happens in the cycle where the counter accepts a
    // new level of 1.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            rise[b] = sync2[b] & ~level[b] & (deb_cnt[b] == DEB_LAST);
        end
    end

    // An edge that coincides with frame_done counts for this frame directly,
    // because the flag is being cleared in that same cycle.
    assign press = flag | rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            flag  <= '0;
            for (int b = 0; b < 2; b++) begin
                deb_cnt[b] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] == level[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == DEB_LAST) begin
                    level[b]   <= sync2[b];
                    deb_cnt[b] <= '0;
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + 1'b1;
                end
            end
            flag <= frame_done ? 2'b00 : (flag | rise);
        end
    end

    state_t     state_q, state_n;
    logic [4:0] cursor_q, cursor_n;
    logic [4:0] stone_q, stone_n;
    logic [7:0] score_q, score_n;
    logic [7:0] tick_q, tick_n;
    logic [7:0] period_q, period_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= TITLE;
            cursor_q <= 5'd0;
            stone_q  <= 5'd31;
            score_q  <= 8'd0;
            tick_q   <= 8'd0;
            period_q <= TICK_P;
        end else begin
            state_q  <= state_n;
            cursor_q <= cursor_n;
            stone_q  <= stone_n;
            score_q  <= score_n;
            tick_q   <= tick_n;
            period_q <= period_n;
        end
    end

    // The cursor is resolved before the stone steps, so the collision test sees
    // both post-update positions.
    always_comb begin
        state_n  = state_q;
        cursor_n = cursor_q;
        stone_n  = stone_q;
        score_n  = score_q;
        tick_n   = tick_q;
        period_n = period_q;
        case (state_q)
            TITLE, DEAD: begin
                if (frame_done && (press != 2'b00)) begin
                    state_n  = PLAY;
                    cursor_n = 5'd0;
                    stone_n  = 5'd31;
                    score_n  = 8'd0;
                    tick_n   = 8'd0;
                    period_n = TICK_P;
                end
            end
            PLAY: begin
                if (frame_done) begin
                    if (press == 2'b01) begin
                        cursor_n = 5'd0;
                    end else if (press == 2'b10) begin
                        cursor_n = 5'd16;
                    end
                    if (tick_q == period_q - 8'd1) begin
                        tick_n = 8'd0;
                        if (stone_q[3:0] != 4'h0) begin
                            stone_n = stone_q - 5'd1;
                        end else begin
                            stone_n = {~stone_q[4], 4'hF};
                            if (score_q != 8'hFF) begin
                                score_n = score_q + 8'd1;
                            end
`ifdef SPEEDUP_EN
                            period_n = (period_q > 8'(MIN_FRAMES)) ?
                                       period_q - 8'd1 : 8'(MIN_FRAMES);
`else
                            period_n = TICK_P;
`endif
                        end
                    end else begin
                        tick_n = tick_q + 8'd1;
                    end
                    if (stone_n == cursor_n) begin
                        state_n = DEAD;
                    end
                end
            end
            default: begin
                state_n = TITLE;
            end
        endcase
    end

    assign game_state = state_q;
    assign cursor     = cursor_q;
    assign stone0     = stone_q;
    assign score      = score_q;

endmodule

// File: tb/tb_lcd_game_engine.sv
// tb_lcd_game_engine
//   Directed bench for lcd_game_engine with short debounce and step periods.
//   Inputs change on the falling clock edge, and outputs are sampled there too.
//   Frames are 40 cycles long, with frame_done in the last cycle.

module tb_lcd_game_engine;

    logic       clk;
    logic       reset;
    logic       upB;
    logic       dwB;
    logic       frame_done;
    logic [1:0] game_state;
    logic [4:0] cursor;
    logic [4:0] stone0;
    logic [7:0] score;

    int total_checks;
    int bad_checks;

    lcd_game_engine #(
        .DEB_W      (16),
        .DEB_CYCLES (4),
        .TICK_FRAMES(2),
        .MIN_FRAMES (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .upB       (upB),
        .dwB       (dwB),
        .frame_done(frame_done),
        .game_state(game_state),
        .cursor    (cursor),
        .stone0    (stone0),
        .score     (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One LCD frame: 39 idle cycles, then one cycle with frame_done high.
    task automatic runFrame();
        waitCycles(39);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    task automatic runFrames(input int n);
        repeat (n) runFrame();
    endtask

    // Hold the buttons for 'hold' cycles, then release and let the release settle.
    task automatic applyStimulus(input logic up, input logic dw, input int hold);
        upB = up;
        dwB = dw;
        waitCycles(hold);
        upB = 1'b0;
        dwB = 1'b0;
        waitCycles(10);
    endtask

    task automatic checkAll(input string tag, input int st, input int cur, input int stn, input int sc);
        checkOutput({tag, ".state"},  32'(game_state), 32'(st));
        checkOutput({tag, ".cursor"}, 32'(cursor),     32'(cur));
        checkOutput({tag, ".stone"},  32'(stone0),     32'(stn));
        checkOutput({tag, ".score"},  32'(score),      32'(sc));
    endtask

    initial begin
        int frames;
        int exp_stone;
        int exp_frames;
        total_checks = 0;
        bad_checks   = 0;
        upB          = 1'b0;
        dwB          = 1'b0;
        frame_done   = 1'b0;
        reset        = 1'b1;
        waitCycles(2);
        reset = 1'b0;
        checkAll("reset", 0, 0, 31, 0);

        // A 3-cycle blip is shorter than the debounce window.
        applyStimulus(1'b1, 1'b0, 3);
        runFrame();
        checkOutput("shortPress.state", 32'(game_state), 32'd0);

        // A proper press starts the game.
        applyStimulus(1'b1, 1'b0, 8);
        checkOutput("preFrameHold.state", 32'(game_state), 32'd0);
        runFrame();
        checkAll("start", 1, 0, 31, 0);

        // Free running with no presses.
        runFrames(2);
        checkAll("step1", 1, 0, 30, 0);
        runFrames(28);
        checkAll("row1col0", 1, 0, 16, 0);
        runFrames(2);
        checkAll("wrap", 1, 0, 15, 1);
`ifdef SPEEDUP_EN
        exp_stone  = 14;
        exp_frames = 14;
`else
        exp_stone  = 15;
        exp_frames = 29;
`endif
        runFrame();
        checkOutput("afterWrap.stone", 32'(stone0), 32'(exp_stone));

        // Let the stone run into the column-0 cursor on row 0.
        frames = 0;
        while (game_state != 2'd3 && frames < 60) begin
            runFrame();
            frames++;
        end
        checkOutput("hitFrames", 32'(frames), 32'(exp_frames));
        checkAll("deadRow0", 3, 0, 0, 1);
        runFrames(10);
        checkAll("deadHold0", 3, 0, 0, 1);

        // Restart from DEAD, move down, and collide on row 1.
        applyStimulus(1'b1, 1'b0, 8);
        runFrame();
        checkAll("restart1", 1, 0, 31, 0);
        applyStimulus(1'b0, 1'b1, 8);
        runFrame();
        checkAll("moveDown", 1, 16, 31, 0);
        runFrames(28);
        checkAll("nearHit", 1, 16, 17, 0);
        runFrame();
        checkAll("deadRow1", 3, 16, 16, 0);
        runFrames(10);
        checkAll("deadHold1", 3, 16, 16, 0);

        // Both buttons in one frame leave the cursor where it is.
        applyStimulus(1'b1, 1'b0, 8);
        runFrame();
        checkAll("restart2", 1, 0, 31, 0);
        applyStimulus(1'b1, 1'b1, 8);
        runFrame();
        checkAll("bothAtTop", 1, 0, 31, 0);
        applyStimulus(1'b0, 1'b1, 8);
        runFrame();
        checkAll("downAgain", 1, 16, 30, 0);
        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b0, 1'b1, 8);
        runFrame();
        checkAll("bothAtBottom", 1, 16, 30, 0);

        // A reset in mid-game discards everything and does not create a press.
        upB   = 1'b1;
        waitCycles(3);
        reset = 1'b1;
        waitCycles(2);
        reset = 1'b0;
        upB   = 1'b0;
        checkAll("midReset", 0, 0, 31, 0);
        runFrame();
        checkOutput("noPressAfterReset.state", 32'(game_state), 32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
